// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with a valid/ready handshake on both sides.
// After every FRAME_LEN data bits it appends two zero tail bits so the trellis ends in state 00.
module conv_encoder_k3 #(
  parameter int         FRAME_LEN = 16,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_pair,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int             CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {DATA, TAIL} state_t;

  state_t        state, state_next;
  logic [1:0]    s;          // s[1] is the most recent bit
  logic [CW-1:0] bit_cnt;
  logic          tail_cnt;

  logic          slot_free;
  logic          advance;
  logic          b;
  logic          last_step;
  logic          frame_end;
  logic [2:0]    w;
  logic [1:0]    pair_next;

  assign slot_free = !out_valid || out_ready;
  assign frame_end = (bit_cnt == LAST_CNT);
  assign w         = {b, s};
  assign pair_next = {^(w & G1), ^(w & G0)};
  assign busy      = (bit_cnt != '0) || (state == TAIL);

  // NOTE: every output of this block gets a default first; otherwise a path that
  // skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    advance    = 1'b0;
    b          = 1'b0;
    last_step  = 1'b0;
    unique case (state)
      DATA: begin
        in_ready = slot_free;
        advance  = in_valid && slot_free;
        b        = in_bit;
        if (advance && frame_end) state_next = TAIL;
      end
      TAIL: begin
        advance   = slot_free;
        last_step = tail_cnt;
        if (advance && tail_cnt) state_next = DATA;
      end
      default: state_next = DATA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DATA;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pair  <= 2'b00;
      out_last  <= 1'b0;
      s         <= 2'b00;
      bit_cnt   <= '0;
      tail_cnt  <= 1'b0;
    end else if (advance) begin
      // A new symbol replaces the old one even when it is consumed this cycle.
      out_pair  <= pair_next;
      out_valid <= 1'b1;
      out_last  <= last_step;
      s         <= last_step ? 2'b00 : {b, s[1]};
      if (state == DATA) bit_cnt  <= frame_end ? '0 : bit_cnt + CW'(1);
      else               tail_cnt <= ~tail_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed bench for conv_encoder_k3 (FRAME_LEN=4): vector table plus hand-written
// back-to-back frame and mid-frame reset sequences.
module tb_conv_encoder_k3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_bit, in_ready;
  logic       out_valid, out_ready, out_last, busy;
  logic [1:0] out_pair;

  int n_cmp = 0;
  int n_err = 0;

  conv_encoder_k3 #(.FRAME_LEN(4), .G0(3'b111), .G1(3'b101)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_pair (out_pair),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       iv, ib, ordy;
    logic       e_ir, e_ov;
    logic [1:0] e_pair;
    logic       e_last, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic iv, logic ib, logic ordy,
                              logic e_ir, logic e_ov, logic [1:0] e_pair,
                              logic e_last, logic e_busy);
    vec_t v;
    v.name = name; v.iv = iv; v.ib = ib; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pair = e_pair;
    v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check in_ready before the edge, registered outputs after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    in_valid  = v.iv;
    in_bit    = v.ib;
    out_ready = v.ordy;
    #1;
    check({v.name, ".in_ready"}, 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    #1;
    check({v.name, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({v.name, ".out_pair"},  32'(out_pair),  32'(v.e_pair));
    check({v.name, ".out_last"},  32'(out_last),  32'(v.e_last));
    check({v.name, ".busy"},      32'(busy),      32'(v.e_busy));
  endtask

  initial begin
    logic [1:0] exp12 [12];
    logic [7:0] bits8;
    logic [1:0] exp6 [6];
    int idx;

    //                 name   iv ib or  ir ov pair  last busy
    // frame 1,0,1,1 with out_ready high
    vecs.push_back(mk("s1_0", 1, 1, 1, 1, 1, 2'b11, 0, 1));
    vecs.push_back(mk("s1_1", 1, 0, 1, 1, 1, 2'b01, 0, 1));
    vecs.push_back(mk("s1_2", 1, 1, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("s1_3", 1, 1, 1, 1, 1, 2'b10, 0, 1));
    vecs.push_back(mk("s1_t0", 0, 0, 1, 0, 1, 2'b10, 0, 1));
    vecs.push_back(mk("s1_t1", 0, 0, 1, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk("s1_idle", 0, 0, 1, 1, 0, 2'b11, 0, 0));
    // all-zero frame
    vecs.push_back(mk("z_0", 1, 0, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("z_1", 1, 0, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("z_2", 1, 0, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("z_3", 1, 0, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("z_t0", 0, 0, 1, 0, 1, 2'b00, 0, 1));
    vecs.push_back(mk("z_t1", 0, 0, 1, 0, 1, 2'b00, 1, 0));
    vecs.push_back(mk("z_idle", 0, 0, 1, 1, 0, 2'b00, 0, 0));
    // input starvation: in_valid toggling
    vecs.push_back(mk("st_0", 1, 1, 1, 1, 1, 2'b11, 0, 1));
    vecs.push_back(mk("st_g0", 0, 1, 1, 1, 0, 2'b11, 0, 1));
    vecs.push_back(mk("st_1", 1, 0, 1, 1, 1, 2'b01, 0, 1));
    vecs.push_back(mk("st_g1", 0, 1, 1, 1, 0, 2'b01, 0, 1));
    vecs.push_back(mk("st_2", 1, 1, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("st_g2", 0, 0, 1, 1, 0, 2'b00, 0, 1));
    vecs.push_back(mk("st_3", 1, 1, 1, 1, 1, 2'b10, 0, 1));
    vecs.push_back(mk("st_t0", 0, 0, 1, 0, 1, 2'b10, 0, 1));
    vecs.push_back(mk("st_t1", 0, 0, 1, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk("st_idle", 0, 0, 1, 1, 0, 2'b11, 0, 0));
    // backpressure after first symbol, including a stall in TAIL and on the last symbol
    vecs.push_back(mk("bp_0", 1, 1, 1, 1, 1, 2'b11, 0, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("bp_hold%0d", i), 1, 0, 0, 0, 1, 2'b11, 0, 1));
    vecs.push_back(mk("bp_1", 1, 0, 1, 1, 1, 2'b01, 0, 1));
    vecs.push_back(mk("bp_2", 1, 1, 1, 1, 1, 2'b00, 0, 1));
    vecs.push_back(mk("bp_3", 1, 1, 1, 1, 1, 2'b10, 0, 1));
    vecs.push_back(mk("bp_t0", 0, 0, 1, 0, 1, 2'b10, 0, 1));
    vecs.push_back(mk("bp_thold", 0, 0, 0, 0, 1, 2'b10, 0, 1));
    vecs.push_back(mk("bp_t1", 0, 0, 1, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk("bp_lhold", 0, 0, 0, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk("bp_idle", 0, 0, 1, 1, 0, 2'b11, 0, 0));

    // reset state
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_pair",  32'(out_pair),  32'd0);
    check("rst.out_last",  32'(out_last),  32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // back-to-back frames 1011 1011, in_valid held high, no bubbles
    bits8 = 8'b1101_1101;  // bit k at index k, LSB first: 1,0,1,1,1,0,1,1
    exp12 = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11,
              2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_bit    = (idx < 8) ? bits8[idx[2:0]] : 1'b0;
      out_ready = 1'b1;
      #1;
      check($sformatf("b2b_%0d.in_ready", k), 32'(in_ready),
            32'((k % 6) < 4));
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      check($sformatf("b2b_%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("b2b_%0d.out_pair", k),  32'(out_pair),  32'(exp12[k]));
      check($sformatf("b2b_%0d.out_last", k),  32'(out_last),  32'(k == 5 || k == 11));
    end
    check("b2b.bits_taken", 32'(idx), 32'd8);
    step(mk("b2b_idle", 0, 0, 1, 1, 0, 2'b11, 0, 0));

    // mid-frame reset after two accepted bits (1,0 leaves s=01)
    step(mk("mr_0", 1, 1, 1, 1, 1, 2'b11, 0, 1));
    step(mk("mr_1", 1, 0, 1, 1, 1, 2'b01, 0, 1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mr.out_valid", 32'(out_valid), 32'd0);
    check("mr.busy",      32'(busy),      32'd0);
    check("mr.out_last",  32'(out_last),  32'd0);
    check("mr.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    exp6 = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    for (int k = 0; k < 6; k++)
      step(mk($sformatf("mr_f%0d", k), k < 4, (k != 1) && (k < 4), 1,
              k < 4, 1, exp6[k], k == 5, k != 5));
    step(mk("mr_idle", 0, 0, 1, 1, 0, 2'b11, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. This is the transmit-side counterpart of the Viterbi decoder's branch-metric and ACS chain.
- Accepts a serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per input bit.
- After every FRAME_LEN data bits it appends K-1 = 2 zero tail bits, so the trellis terminates in state 00, which the decoder's traceback assumes.
- Sits between the bench/source and the channel-noise model feeding the decoder's rx_pair input.

Parameters:
- FRAME_LEN, 16: data bits per frame before tail insertion; legal range 1..1024.
- G0, 3'b111: generator polynomial for out_pair[0]; bit 2 taps the current bit, bit 0 taps the oldest bit.
- G1, 3'b101: generator polynomial for out_pair[1]; same tap ordering.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  data bit.
- in_ready  output  1  encoder accepts in_bit this cycle.
- out_valid  output  1  out_pair holds a valid symbol.
- out_pair  output  2  code symbol {p1,p0}.
- out_ready  input  1  downstream consumes the symbol this cycle.
- out_last  output  1  qualifies out_pair as the final tail symbol of a frame.
- busy  output  1  high when mid-frame (bit_cnt != 0) or in TAIL.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values:
  - out_valid = 0, out_pair = 2'b00, out_last = 0.
  - State register s[1:0] = 2'b00; s[1] is the most recent bit.
  - bit_cnt = 0, FSM = DATA.
  - Combinational outputs after reset: in_ready = 1, busy = 0.
- Output slot: a single registered stage. slot_free = !out_valid || out_ready.
- Datapath: window w = {b, s[1], s[0]}.
  - p0 = ^(w & G0), p1 = ^(w & G1).
  - On each advance: s <= {b, s[1]}.
- FSM DATA:
  - in_ready = slot_free.
  - Advance when in_valid && in_ready, with b = in_bit.
  - On advance: out_pair <= {p1,p0}, out_valid <= 1, bit_cnt++.
  - When the accepted bit is the FRAME_LEN-th: bit_cnt <= 0, go to TAIL.
- FSM TAIL:
  - in_ready = 0.
  - Advance with b = 0 whenever slot_free (in_valid ignored).
  - Tail counter 0..1.
  - The second tail advance sets out_last <= 1 with that symbol, clears s to 00 and returns to DATA.
- out_last clears when its symbol is consumed, unless it is replaced by another last symbol (impossible by construction).
- Latency: the symbol appears on out_pair the cycle after its bit is accepted (or its tail step occurs).
- Throughput: 1 symbol/cycle with out_ready held high. A frame occupies FRAME_LEN+2 output cycles.
- Back-to-back frames: the first bit of the next frame is accepted in the same cycle the last tail symbol is consumed; there are no bubbles.
- Consumption without refill: if the slot empties and no advance occurs, out_valid <= 0 and out_pair holds its last value.
- Backpressure: while out_valid && !out_ready, out_pair, out_valid, out_last, s and bit_cnt are all frozen and in_ready = 0.
- Simultaneous consume + advance in the same cycle: the new symbol replaces the old one and out_valid stays 1.
- Reset mid-frame: the partial frame is discarded, no tail is emitted, and all state returns to reset values immediately (asynchronous).
- bit_cnt width: $clog2(FRAME_LEN+1).
- The tail counter is a separate 1-bit register.

Test Plan:
- FRAME_LEN=4, out_ready=1, input bits 1,0,1,1 on consecutive cycles. Required out_pair sequence: 11, 01, 00, 10 (data), then 10, 11 (tail), with out_last=1 only on the final 11; in_ready=0 for the 2 tail cycles.
- All-zero frame, FRAME_LEN=4: 6 symbols, all 00; out_last on the 6th; busy high from the first accept through the last tail step.
- Backpressure: out_ready=0 for 5 cycles after the first symbol 11. Required: out_pair stays 11 and out_valid stays 1; in_ready=0; the next input is not consumed; the sequence resumes unchanged after release.
- Input starvation: in_valid toggling 1/0 with out_ready=1. Required: out_valid drops in gap cycles, the encoded sequence is identical to the first scenario, and bit_cnt advances only on accepts.
- Back-to-back frames, FRAME_LEN=4: bits 1011 then 1011 with in_valid held high. Required: 12 symbols, 11 01 00 10 10 11 11 01 00 10 10 11, out_last on symbols 6 and 12, and no idle cycle between frames.
- rst pulsed after 2 accepted bits. Required: out_valid=0 and busy=0 immediately. A following frame 1,0,1,1 then yields 11, 01, 00, 10, 10, 11, proving s was cleared.
